spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
Clock-domain SPI target that consumes the sclk/ss/mosi lines produced by the team's spi master and returns miso. It oversamples the SPI lines in the system clock domain and supports all four SPI modes, MSB first. Each frame is N_bytes long; received frames are presented as parallel words and transmit words are loaded per frame. It serves as the loop-back/peripheral partner for master bring-up and as a real slave port.

Parameters:
N_bytes, 1, bytes per frame; frame width W = N_bytes*8.
mode, 0, SPI mode 0..3; CPOL = mode[1], CPHA = mode[0].

Ports:
clk  in  1  system clock; sclk frequency must not exceed clk/8.
rst_n  in  1  asynchronous active-low reset.
sclk  in  1  SPI clock from master, asynchronous to clk.
ss  in  1  slave select, active low, asynchronous.
mosi  in  1  serial data from master.
miso  out  1  serial data to master.
tx_data  in  W  word to transmit; sampled at frame start.
tx_ack  out  1  one-cycle pulse: tx_data has been latched.
rx_data  out  W  last complete received frame.
rx_valid  out  1  one-cycle pulse: rx_data updated.
frame_err  out  1  one-cycle pulse: frame aborted by ss rising mid-frame.
busy  out  1  high while a frame is in progress (synchronized ss low).

Behaviour:
- Reset (async, rst_n=0): miso=0, tx_ack=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, state IDLE, bit counter 0, shift registers 0, synchronizer flops reset to idle levels (sclk=CPOL, ss=1). Reset mid-frame discards the frame silently; no frame_err.
- sclk and ss pass through 2-flop synchronizers, then a 1-flop edge detector; mosi through 2 flops, aligned with sclk.
- Sample edge: rising for modes 0 and 3, falling for modes 1 and 2. Shift edge is the opposite edge.
- FSM IDLE: miso=0, busy=0. On synchronized ss falling edge: latch tx_data into tx shift register, pulse tx_ack, clear bit counter, go ACTIVE.
- ACTIVE, CPHA=0 (modes 0, 2): tx MSB drives miso in the same cycle tx_data is latched. Each later shift edge presents the next bit.
- ACTIVE, CPHA=1 (modes 1, 3): miso holds at 0 until the first shift edge, then presents MSB. Each later shift edge presents the next bit.
- On each sample edge, the synchronized mosi shifts into the rx register LSB-side; counter increments.
- Counter reaches W: rx_data <= rx shift register, rx_valid pulses one cycle, counter wraps to 0, and tx_data is re-latched with a tx_ack pulse.
- Burst behaviour: frames continue back-to-back while ss stays low. For CPHA=0, the new MSB appears on miso immediately after re-latch.
- Synchronized ss rising edge: if counter is 0, return to IDLE with no pulse. Otherwise pulse frame_err, discard partial data, leave rx_data unchanged, return to IDLE.
- Simultaneous final sample edge and ss rise in the same cycle: frame counts as complete (rx_valid, no frame_err).
- Latency: rx_valid rises on the 4th clk rising edge after raw sclk shows the final sampling transition (2 sync + 1 edge + 1 register).
- busy = state==ACTIVE. Edges of sclk while in IDLE are ignored.

Decomposition:
- Package spi_pkg: mode type (0..3), functions cpol(mode)/cpha(mode), FSM enum {IDLE, ACTIVE}, and shared constant SYNC_STAGES=2 used by this block and the master testbench.
- One sub-module spi_sync_edge: generic 2-flop synchronizer with rise/fall pulse outputs and a reset-value parameter. It is instantiated for sclk and for ss.

Test Plan:
1. mode 0, N_bytes=1, tx_data=8'hA5, spi master sends 8'h5A -> rx_data=8'h5A with a single rx_valid pulse; master out_data=8'hA5; tx_ack pulses once.
2. Repeat test 1 in modes 1, 2 and 3 -> same values in each mode. miso stays at 0 while ss is high; in CPHA=1 modes miso stays at 0 before the first shift edge.
3. Burst, mode 0, ss held low for 3 frames, master sends 8'h01, 8'h02, 8'h03 while tx_data steps 8'h10, 8'h11, 8'h12 on each tx_ack -> three rx_valid pulses with 01, 02, 03; master receives 10, 11, 12.
4. Abort: ss rises after 5 sclk cycles of 8'hFF -> one frame_err pulse, no rx_valid, rx_data keeps its previous value. The next full frame 8'h3C is received correctly.
5. Reset mid-frame: rst_n low after 3 bits -> all outputs 0 immediately (async), no frame_err. The following frame 8'hC3 is received correctly.
6. N_bytes=2, mode 3, master sends 16'hBEEF, tx_data=16'h1234 -> rx_data=16'hBEEF, master gets 16'h1234; one rx_valid, 4 clk edges after the last sampling edge.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode decoding, slave FSM states and synchronizer depth.
package spi_pkg;

  typedef logic [1:0] mode_t;

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int SYNC_STAGES = 2;

  function automatic logic cpol(input mode_t m);
    return m[1];
  endfunction

  function automatic logic cpha(input mode_t m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level with registered rise/fall pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI target oversampled in the clk domain; all four modes, MSB first, N_bytes per frame.
module spi_slave
  import spi_pkg::*;
#(
  parameter int N_bytes = 1,
  parameter int mode    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 ss,
  input  logic                 mosi,
  output logic                 miso,
  input  logic [N_bytes*8-1:0] tx_data,
  output logic                 tx_ack,
  output logic [N_bytes*8-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int    W           = N_bytes * 8;
  localparam int    CW          = $clog2(W + 1);
  localparam mode_t M           = mode_t'(mode);
  localparam logic  CPOL        = cpol(M);
  localparam logic  CPHA        = cpha(M);
  localparam logic  SAMPLE_RISE = (CPOL == CPHA);

  state_t                 state_q, state_d;
  logic   [CW-1:0]        cnt;
  logic   [W-1:0]         tx_shift;
  logic   [W-2:0]         rx_shift;
  logic   [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic                   sample_edge, shift_edge;
  logic                   load, sample_en, shift_en, finish, abort, quit;

  spi_sync_edge #(.RESET_VAL(CPOL)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ss),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s      = mosi_q[SYNC_STAGES-1];
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign busy        = (state_q == ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // With CPHA=0 the shift edge that trails the last sample edge must not
  // disturb the freshly re-latched MSB, so shifts are ignored while cnt==0.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    sample_en = 1'b0;
    shift_en  = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    quit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = ACTIVE;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        sample_en = sample_edge;
        shift_en  = shift_edge && (CPHA || cnt != '0);
        finish    = sample_edge && (cnt == CW'(W - 1));
        if (ss_rise) begin
          state_d = IDLE;
          quit    = 1'b1;
          abort   = !finish && (cnt != '0 || sample_edge);
        end else begin
          load = finish;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso      <= 1'b0;
      tx_ack    <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= '0;
      cnt       <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
    end else begin
      tx_ack    <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= abort;
      if (finish) begin
        rx_data  <= {rx_shift, mosi_s};
        rx_valid <= 1'b1;
      end
      if (quit) begin
        cnt      <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
        miso     <= 1'b0;
      end else begin
        if (sample_en) begin
          rx_shift <= {rx_shift[W-3:0], mosi_s};
          cnt      <= cnt + CW'(1);
        end
        if (shift_en) begin
          miso     <= CPHA ? tx_shift[W-1] : tx_shift[W-2];
          tx_shift <= {tx_shift[W-2:0], 1'b0};
        end
        if (load) begin
          tx_shift <= tx_data;
          tx_ack   <= 1'b1;
          cnt      <= '0;
          rx_shift <= '0;
          if (!CPHA) miso <= tx_data[W-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench: bit-level SPI master model driving one slave per mode plus a 16-bit mode-3 slave.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int HP = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] sclk_a, ss_a, mosi_a, miso_a, ack_a, rxv_a, err_a, busy_a;
  logic [7:0] tx8 [4];
  logic [7:0] rx8 [4];
  logic [15:0] tx16, rx16;

  int n_assert = 0;
  int n_fail   = 0;
  int rxv_cnt [5] = '{default: 0};
  int ack_cnt [5] = '{default: 0};
  int err_cnt [5] = '{default: 0};
  logic [15:0] cap [5][4];
  logic [15:0] model_last [5] = '{default: 16'h0};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      spi_slave #(.N_bytes(1), .mode(g)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk_a[g]),
        .ss       (ss_a[g]),
        .mosi     (mosi_a[g]),
        .miso     (miso_a[g]),
        .tx_data  (tx8[g]),
        .tx_ack   (ack_a[g]),
        .rx_data  (rx8[g]),
        .rx_valid (rxv_a[g]),
        .frame_err(err_a[g]),
        .busy     (busy_a[g])
      );
    end
  endgenerate

  spi_slave #(.N_bytes(2), .mode(3)) u_dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk_a[4]),
    .ss       (ss_a[4]),
    .mosi     (mosi_a[4]),
    .miso     (miso_a[4]),
    .tx_data  (tx16),
    .tx_ack   (ack_a[4]),
    .rx_data  (rx16),
    .rx_valid (rxv_a[4]),
    .frame_err(err_a[4]),
    .busy     (busy_a[4])
  );

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rxv_a[i]) begin
        if (i == 4) cap[i][rxv_cnt[i] % 4] = rx16;
        else        cap[i][rxv_cnt[i] % 4] = {8'h00, rx8[i]};
        rxv_cnt[i]++;
      end
      if (ack_a[i]) ack_cnt[i]++;
      if (err_a[i]) err_cnt[i]++;
    end
  end

  function automatic mode_t mode_of(input int idx);
    return (idx == 4) ? 2'd3 : mode_t'(idx);
  endfunction

  function automatic logic [15:0] rx_of(input int idx);
    if (idx == 4) return rx16;
    return {8'h00, rx8[idx]};
  endfunction

  task automatic hp_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_tx(input int idx, input logic [15:0] v);
    if (idx == 4) tx16 = v;
    else          tx8[idx] = v[7:0];
  endtask

  function automatic logic [15:0] rand_word(input int idx);
    logic [15:0] v;
    v = 16'($urandom);
    if (idx != 4) v[15:8] = 8'h00;
    return v;
  endfunction

  // Master side of one frame (ss handled by the caller); lat counts clk edges
  // from the final sampling transition to rx_valid.
  task automatic frame(input int idx, input int nbits, input logic [15:0] mo,
                       input int nsend, output logic [15:0] mi, output int lat);
    mode_t m;
    int    n;
    m   = mode_of(idx);
    mi  = '0;
    lat = -1;
    for (int b = 0; b < nsend; b++) begin
      if (!m[0]) begin
        mosi_a[idx] = mo[nbits-1-b];
        hp_wait(HP);
      end else begin
        sclk_a[idx] = ~sclk_a[idx];
        mosi_a[idx] = mo[nbits-1-b];
        hp_wait(HP);
      end
      sclk_a[idx] = ~sclk_a[idx];
      mi = {mi[14:0], miso_a[idx]};
      n = 0;
      while (n < HP) begin
        @(posedge clk);
        #1;
        n++;
        if (rxv_a[idx] && lat < 0 && b == nbits - 1) lat = n;
      end
      if (!m[0]) sclk_a[idx] = ~sclk_a[idx];
    end
  endtask

  task automatic txn(input int idx, input logic [15:0] tx, input logic [15:0] mo, input string tag);
    int          nb, lat, rv0, ak0, er0;
    mode_t       m;
    logic [15:0] mi;
    nb  = (idx == 4) ? 16 : 8;
    m   = mode_of(idx);
    rv0 = rxv_cnt[idx];
    ak0 = ack_cnt[idx];
    er0 = err_cnt[idx];
    set_tx(idx, tx);
    chk({tag, "_idle_miso"}, 32'(miso_a[idx]), 32'(0));
    ss_a[idx] = 1'b0;
    hp_wait(HP);
    chk({tag, "_busy_on"}, 32'(busy_a[idx]), 32'(1));
    chk({tag, "_ack_start"}, 32'(ack_cnt[idx] - ak0), 32'(1));
    chk({tag, "_first_miso"}, 32'(miso_a[idx]), m[0] ? 32'(0) : 32'(tx[nb-1]));
    frame(idx, nb, mo, nb, mi, lat);
    ss_a[idx] = 1'b1;
    hp_wait(HP);
    chk({tag, "_rx_data"}, 32'(rx_of(idx)), 32'(mo));
    chk({tag, "_master_rx"}, 32'(mi), 32'(tx));
    chk({tag, "_rx_valid_cnt"}, 32'(rxv_cnt[idx] - rv0), 32'(1));
    chk({tag, "_frame_err_cnt"}, 32'(err_cnt[idx] - er0), 32'(0));
    chk({tag, "_latency"}, 32'(lat), 32'(4));
    chk({tag, "_busy_off"}, 32'(busy_a[idx]), 32'(0));
    chk({tag, "_end_miso"}, 32'(miso_a[idx]), 32'(0));
    model_last[idx] = mo;
  endtask

  initial begin
    logic [15:0] mi;
    int          lat, rv0, ak0, er0;

    rst_n  = 1'b0;
    sclk_a = 5'b11100;
    ss_a   = '1;
    mosi_a = '0;
    tx16   = '0;
    for (int i = 0; i < 4; i++) tx8[i] = '0;
    hp_wait(3);
    for (int i = 0; i < 5; i++) begin
      chk("reset_miso", 32'(miso_a[i]), 32'(0));
      chk("reset_busy", 32'(busy_a[i]), 32'(0));
      chk("reset_rx_data", 32'(rx_of(i)), 32'(0));
      chk("reset_pulses", 32'({ack_a[i], rxv_a[i], err_a[i]}), 32'(0));
    end
    rst_n = 1'b1;
    hp_wait(4);

    for (int i = 0; i < 4; i++) txn(i, 16'h00A5, 16'h005A, $sformatf("mode%0d", i));
    txn(4, 16'h1234, 16'hBEEF, "n2_mode3");

    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 5; i++)
        txn(i, rand_word(i), rand_word(i), $sformatf("rand%0d_dut%0d", r, i));

    rv0 = rxv_cnt[0];
    er0 = err_cnt[0];
    set_tx(0, 16'h0010);
    ss_a[0] = 1'b0;
    hp_wait(HP);
    for (int k = 0; k < 3; k++) begin
      set_tx(0, (k < 2) ? 16'(16'h0011 + k) : 16'h0012);
      frame(0, 8, 16'(16'h0001 + k), 8, mi, lat);
      chk($sformatf("burst_master_rx%0d", k), 32'(mi), 32'(16'h0010 + k));
    end
    ss_a[0] = 1'b1;
    hp_wait(HP);
    chk("burst_rx_valid_cnt", 32'(rxv_cnt[0] - rv0), 32'(3));
    for (int k = 0; k < 3; k++)
      chk($sformatf("burst_rx%0d", k), 32'(cap[0][(rv0 + k) % 4]), 32'(16'h0001 + k));
    chk("burst_frame_err", 32'(err_cnt[0] - er0), 32'(0));
    model_last[0] = 16'h0003;

    rv0 = rxv_cnt[0];
    er0 = err_cnt[0];
    ss_a[0] = 1'b0;
    hp_wait(HP);
    frame(0, 8, 16'h00FF, 5, mi, lat);
    ss_a[0] = 1'b1;
    hp_wait(HP);
    hp_wait(HP);
    chk("abort_frame_err_cnt", 32'(err_cnt[0] - er0), 32'(1));
    chk("abort_rx_valid_cnt", 32'(rxv_cnt[0] - rv0), 32'(0));
    chk("abort_rx_kept", 32'(rx_of(0)), 32'(model_last[0]));
    txn(0, rand_word(0), 16'h003C, "after_abort");

    er0 = err_cnt[0];
    ak0 = ack_cnt[0];
    ss_a[0] = 1'b0;
    hp_wait(HP);
    frame(0, 8, 16'h00FF, 3, mi, lat);
    rst_n = 1'b0;
    #1;
    chk("midrst_miso", 32'(miso_a[0]), 32'(0));
    chk("midrst_busy", 32'(busy_a[0]), 32'(0));
    chk("midrst_rx_data", 32'(rx_of(0)), 32'(0));
    chk("midrst_pulses", 32'({ack_a[0], rxv_a[0], err_a[0]}), 32'(0));
    ss_a[0] = 1'b1;
    hp_wait(HP);
    rst_n = 1'b1;
    hp_wait(HP);
    chk("midrst_no_frame_err", 32'(err_cnt[0] - er0), 32'(0));
    chk("midrst_ack_only_start", 32'(ack_cnt[0] - ak0), 32'(1));
    model_last[0] = 16'h0000;
    txn(0, rand_word(0), 16'h00C3, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
